// File: rtl/arilla_bus_arbiter.sv
// rtl/arilla_bus_arbiter.sv - round-robin bus arbiter with optional lock and one-cycle response
module arilla_bus_arbiter #(
  parameter int Requesters   = 3,
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32,
  parameter int BytesPerWord = 4,
  parameter int LockTimeout  = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [Requesters-1:0]              i_req_read,
  input  logic [Requesters-1:0]              i_req_write,
  input  logic [Requesters-1:0]              i_req_lock,
  input  logic [Requesters*AddressWidth-1:0] i_req_address,
  input  logic [Requesters*BytesPerWord-1:0] i_req_byte_enable,
  input  logic [Requesters*DataWidth-1:0]    i_req_data,
  output logic [Requesters-1:0]              o_grant,
  output logic [Requesters-1:0]              o_rsp_valid,
  output logic [DataWidth-1:0]               o_rsp_data,
  output logic                               o_rsp_err,
  output logic                               o_locked,
  output logic [AddressWidth-1:0]            o_bus_address,
  output logic [BytesPerWord-1:0]            o_bus_byte_enable,
  output logic [DataWidth-1:0]               o_bus_data_ctp,
  output logic                               o_bus_read,
  output logic                               o_bus_write,
  input  logic                               i_bus_hit,
  input  logic [DataWidth-1:0]               i_bus_data_ptc
);

  localparam int IW = (Requesters > 1) ? $clog2(Requesters) : 1;
  localparam int CW = $clog2(LockTimeout + 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= Requesters) s = s - Requesters;
    return s[IW-1:0];
  endfunction

  logic [Requesters-1:0] w_active;
  logic [Requesters-1:0] w_grant;
  logic                  w_found;
  logic [IW-1:0]         w_gnt_idx;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_owner, w_owner_nxt;
  logic [CW-1:0]         r_idle, w_idle_nxt;
  logic [IW-1:0]         r_ptr;

  logic                  r_rsp_pending;
  logic [Requesters-1:0] r_rsp_owner;
  logic                  r_rsp_err;
  logic                  r_rsp_read;
  logic                  w_rsp_live;

  assign w_active = i_req_read | i_req_write;

  // While locked only the owner is eligible; otherwise scan upward from r_ptr.
  always_comb begin
    w_grant   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    if (!i_rst) begin
      if (r_state == ST_LOCKED) begin
        if (w_active[r_owner]) begin
          w_found   = 1'b1;
          w_gnt_idx = r_owner;
        end
      end else begin
        for (int k = 0; k < Requesters; k++) begin
          if (!w_found && w_active[wrap_inc(r_ptr, k)]) begin
            w_found   = 1'b1;
            w_gnt_idx = wrap_inc(r_ptr, k);
          end
        end
      end
      if (w_found) w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign o_grant = w_grant;

  always_comb begin
    o_bus_address     = '0;
    o_bus_byte_enable = '0;
    o_bus_data_ctp    = '0;
    o_bus_read        = 1'b0;
    o_bus_write       = 1'b0;
    for (int i = 0; i < Requesters; i++) begin
      if (w_grant[i]) begin
        o_bus_address     = i_req_address[i*AddressWidth +: AddressWidth];
        o_bus_byte_enable = i_req_byte_enable[i*BytesPerWord +: BytesPerWord];
        o_bus_data_ctp    = i_req_data[i*DataWidth +: DataWidth];
        o_bus_read        = i_req_read[i] & ~i_req_write[i];
        o_bus_write       = i_req_write[i];
      end
    end
  end

  // Lock FSM: a locked grant with req_lock low is the last of the sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_idle_nxt  = r_idle;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_found && i_req_lock[w_gnt_idx]) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_gnt_idx;
          w_idle_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (w_found) begin
          w_idle_nxt = '0;
          if (!i_req_lock[r_owner]) w_state_nxt = ST_UNLOCKED;
        end else if (r_idle == CW'(LockTimeout - 1)) begin
          w_state_nxt = ST_UNLOCKED;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_UNLOCKED;
      r_owner       <= '0;
      r_idle        <= '0;
      r_ptr         <= '0;
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_read    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_idle  <= w_idle_nxt;
      if (r_state == ST_UNLOCKED && w_found) r_ptr <= wrap_inc(w_gnt_idx, 1);
      r_rsp_pending <= w_found;
      r_rsp_owner   <= w_grant;
      r_rsp_err     <= w_found & ~i_bus_hit;
      r_rsp_read    <= o_bus_read;
    end
  end

  // A response still pending when reset arrives is suppressed immediately.
  assign w_rsp_live  = r_rsp_pending & ~i_rst;
  assign o_rsp_valid = w_rsp_live ? r_rsp_owner : '0;
  assign o_rsp_err   = w_rsp_live & r_rsp_err;
  assign o_rsp_data  = (w_rsp_live && r_rsp_read && !r_rsp_err) ? i_bus_data_ptc : '0;
  assign o_locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb/tb_arilla_bus_arbiter.sv - directed self-checking bench for arilla_bus_arbiter
module tb_arilla_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_read, req_write, req_lock;
  logic [N*AW-1:0] req_address;
  logic [N*BW-1:0] req_byte_enable;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err, locked;
  logic [AW-1:0]   bus_address;
  logic [BW-1:0]   bus_byte_enable;
  logic [DW-1:0]   bus_data_ctp;
  logic            bus_read, bus_write;
  logic            bus_hit;
  logic [DW-1:0]   bus_data_ptc;

  int n_cmp = 0;
  int n_err = 0;

  arilla_bus_arbiter #(
    .Requesters(N), .AddressWidth(AW), .DataWidth(DW), .BytesPerWord(BW), .LockTimeout(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_read(req_read), .i_req_write(req_write), .i_req_lock(req_lock),
    .i_req_address(req_address), .i_req_byte_enable(req_byte_enable), .i_req_data(req_data),
    .o_grant(grant), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_locked(locked), .o_bus_address(bus_address), .o_bus_byte_enable(bus_byte_enable),
    .o_bus_data_ctp(bus_data_ctp), .o_bus_read(bus_read), .o_bus_write(bus_write),
    .i_bus_hit(bus_hit), .i_bus_data_ptc(bus_data_ptc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_read  = '0;
    req_write = '0;
    req_lock  = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    req_address     = '0;
    req_byte_enable = '1;
    req_data        = '0;
    bus_hit         = 1'b1;
    bus_data_ptc    = '0;

    // Reset: requests present but grant forced low
    req_read = 3'b111;
    tick();
    tick();
    #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_bus_read", bus_read, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 3'b000);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_locked", locked, 1'b0);

    // Single read by requester 1
    tick();
    rst = 1'b0;
    clear_req();
    req_read[1] = 1'b1;
    req_address[1*AW +: AW] = 30'h10;
    #1;
    chk("t1_grant", grant, 3'b010);
    chk("t1_bus_read", bus_read, 1'b1);
    chk("t1_bus_write", bus_write, 1'b0);
    chk("t1_bus_addr", bus_address, 30'h10);
    tick();
    clear_req();
    bus_data_ptc = 32'hDEADBEEF;
    #1;
    chk("t1_rsp_valid", rsp_valid, 3'b010);
    chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_idle_grant", grant, 3'b000);

    // All three request continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_read = 3'b111;
    #1;
    chk("t2_grant0", grant, 3'b001);
    tick(); #1;
    chk("t2_grant1", grant, 3'b010);
    chk("t2_rsp1", rsp_valid, 3'b001);
    tick(); #1;
    chk("t2_grant2", grant, 3'b100);
    tick(); #1;
    chk("t2_grant3", grant, 3'b001);
    tick();
    clear_req();

    // Locked pair by requester 2 while requester 0 waits (ptr = 1)
    req_read[0]  = 1'b1;
    req_write[2] = 1'b1;
    req_lock[2]  = 1'b1;
    req_address[2*AW +: AW] = 30'h1;
    req_data[2*DW +: DW]    = 32'h0000_1111;
    #1;
    chk("t3_grant_lo", grant, 3'b100);
    chk("t3_write_lo", bus_write, 1'b1);
    chk("t3_addr_lo", bus_address, 30'h1);
    chk("t3_unlocked_lo", locked, 1'b0);
    tick();
    req_lock[2] = 1'b0;
    req_address[2*AW +: AW] = 30'h2;
    #1;
    chk("t3_grant_hi", grant, 3'b100);
    chk("t3_locked_hi", locked, 1'b1);
    chk("t3_addr_hi", bus_address, 30'h2);
    tick();
    req_write[2] = 1'b0;
    bus_data_ptc = 32'h5555AAAA;
    #1;
    chk("t3_unlocked", locked, 1'b0);
    chk("t3_grant_r0", grant, 3'b001);
    chk("t3_rsp_valid", rsp_valid, 3'b100);
    chk("t3_rsp_wdata", rsp_data, 32'h0);
    tick();
    clear_req();

    // Lock owner 0 goes idle while requester 1 waits (ptr = 1)
    req_read[0] = 1'b1;
    req_lock[0] = 1'b1;
    #1;
    chk("t4_grant_lock", grant, 3'b001);
    tick();
    clear_req();
    req_read[1] = 1'b1;
    for (int c = 0; c < TO; c++) begin
      #1;
      chk($sformatf("t4_locked_%0d", c), locked, 1'b1);
      chk($sformatf("t4_blocked_%0d", c), grant, 3'b000);
      tick();
    end
    #1;
    chk("t4_released", locked, 1'b0);
    chk("t4_grant_r1", grant, 3'b010);
    tick();
    clear_req();

    // Unmapped read by requester 0 (ptr = 2)
    req_read[0] = 1'b1;
    req_address[0*AW +: AW] = 30'h3FF_FFF0;
    bus_hit = 1'b0;
    #1;
    chk("t5_grant", grant, 3'b001);
    tick();
    clear_req();
    bus_hit = 1'b1;
    bus_data_ptc = 32'h12345678;
    #1;
    chk("t5_rsp_valid", rsp_valid, 3'b001);
    chk("t5_rsp_err", rsp_err, 1'b1);
    chk("t5_rsp_data", rsp_data, 32'h0);

    // Read and write together on requester 1: write wins
    req_read[1]  = 1'b1;
    req_write[1] = 1'b1;
    req_data[1*DW +: DW] = 32'hCAFEF00D;
    req_byte_enable[1*BW +: BW] = 4'b0011;
    #1;
    chk("t5_rw_grant", grant, 3'b010);
    chk("t5_rw_write", bus_write, 1'b1);
    chk("t5_rw_read", bus_read, 1'b0);
    chk("t5_rw_data", bus_data_ctp, 32'hCAFEF00D);
    chk("t5_rw_be", bus_byte_enable, 4'b0011);
    tick();
    clear_req();
    #1;
    chk("t5_rw_rsp_valid", rsp_valid, 3'b010);
    chk("t5_rw_rsp_err", rsp_err, 1'b0);
    chk("t5_rw_rsp_data", rsp_data, 32'h0);

    // Reset in the cycle after a grant (ptr = 2)
    req_read[2] = 1'b1;
    #1;
    chk("t6_grant", grant, 3'b100);
    tick();
    rst = 1'b1;
    clear_req();
    #1;
    chk("t6_rsp_in_rst", rsp_valid, 3'b000);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rsp_after", rsp_valid, 3'b000);
    req_read = 3'b111;
    #1;
    chk("t6_grant_r0", grant, 3'b001);
    tick();
    clear_req();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arilla_bus_arbiter.md
Name: arilla_bus_arbiter

Overview:
Shares one arilla bus master port between Requesters agents (instruction fetch, data access, debug module) so they can reach the memory-mapped devices, including the machine timer (mtime/mtimecmp) block. Arbitration is round-robin with an optional lock. The lock lets a requester issue back-to-back accesses without interleaving, for example the 64-bit mtime/mtimecmp low/high word pairs. Each granted transaction gets exactly one response cycle, which carries read data and a miss flag.

Parameters:
Requesters, 3, number of requesters (2..8)
AddressWidth, 30, word address width of the bus
DataWidth, 32, data width
BytesPerWord, 4, byte_enable width
LockTimeout, 16, number of consecutive idle cycles of the lock owner before the lock is forcibly released (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_read  in  Requesters  per-requester read request
req_write  in  Requesters  per-requester write request
req_lock  in  Requesters  per-requester lock request, sampled with a grant
req_address  in  Requesters*AddressWidth  packed word addresses, requester i at [i*AddressWidth +: AddressWidth]
req_byte_enable  in  Requesters*BytesPerWord  packed byte enables
req_data  in  Requesters*DataWidth  packed write data
grant  out  Requesters  one-hot combinational grant, transaction issued this cycle
rsp_valid  out  Requesters  one-hot response strobe, one cycle after grant
rsp_data  out  DataWidth  read data for the responding requester
rsp_err  out  1  no device hit the granted address
locked  out  1  lock currently held
bus_address  out  AddressWidth  to bus address
bus_byte_enable  out  BytesPerWord  to bus byte_enable
bus_data_ctp  out  DataWidth  to bus data_ctp
bus_read  out  1  to bus read
bus_write  out  1  to bus write
bus_hit  in  1  bus hit, valid in the address cycle
bus_data_ptc  in  DataWidth  bus read data, valid in the cycle after the address

Behaviour:
- Active request of i: req_read[i] | req_write[i].
- Grant rule when unlocked:
  - grant goes to the first active requester scanning from ptr upward, wrapping at Requesters-1 to 0.
  - If no requester is active, grant is 0.
- Grant rule when locked: only the lock owner may be granted; all others see grant 0 and hold their requests.
- The bus mux selects the granted requester's address, byte_enable and data.
- bus_read = granted & req_read & ~req_write; bus_write = granted & req_write.
  - Read and write asserted together on one requester: the write wins, the read is dropped.
  - No grant: bus_read = bus_write = 0 and address/data = 0.
- Pointer update: on any cycle with a grant to i, ptr <= (i+1) mod Requesters next cycle. ptr is unchanged while locked.
- Response: the registered rsp_owner/rsp_pending produce rsp_valid[owner] = 1 exactly one cycle after the grant, for both reads and writes.
  - rsp_err = registered ~bus_hit from the address cycle.
  - rsp_data = bus_data_ptc for reads and 0 for writes, errors, and when rsp_valid = 0.
- Back-to-back grants are allowed every cycle; the response pipeline is one stage deep and fully pipelined.
- Lock state machine:
  - UNLOCKED -> LOCKED(owner=i): granted cycle with req_lock[i] = 1.
  - LOCKED -> UNLOCKED: owner granted with req_lock = 0 (that grant still completes), or the owner is inactive for LockTimeout consecutive cycles.
  - The idle counter resets on any owner request, saturates, and is cleared on unlock.
- locked = registered state, 1 in LOCKED.
- Reset (rst = 1 at a clock edge): ptr = 0, UNLOCKED, idle counter 0, rsp_valid = 0, rsp_err = 0.
  - grant and bus_read/bus_write are forced to 0 while rst = 1.
  - A response pending at reset is discarded.

Test Plan:
- Only requester 1 reads address 0x10 with hit = 1 and bus_data_ptc = 0xDEADBEEF: grant = 3'b010 in cycle 0; cycle 1 rsp_valid = 3'b010, rsp_data = 0xDEADBEEF, rsp_err = 0.
- All three request continuously from reset: grants cycle 001, 010, 100, 001, and the pointer wraps correctly.
- Requester 2 writes with lock to address 0x1 then 0x2 (mtime low/high pair) while requester 0 also requests: grants 100, 100; requester 0 is granted only after the lock-free write; locked = 1 during the pair.
- Lock owner 0 goes idle with LockTimeout = 16 while requester 1 waits: locked drops after 16 idle cycles and requester 1 is granted the next cycle.
- Read to an unmapped address (hit = 0): rsp_err = 1, rsp_data = 0. Read and write asserted together: only bus_write = 1.
- rst asserted in the cycle after a grant: rsp_valid stays 0 and the next grant after reset starts from requester 0.
